// File: rtl/btn_debounce_pkg.sv
// Shared defaults and sizing helpers for the multi-channel button debouncer.
package btn_debounce_pkg;

  localparam int unsigned DEF_N_CH         = 5;
  localparam int unsigned DEF_CLK_HZ       = 100_000_000;
  localparam int unsigned DEF_TICK_HZ      = 100_000;
  localparam int unsigned DEF_DEPTH        = 8;
  localparam int unsigned DEF_LONG_TICKS   = 100_000;
  localparam int unsigned DEF_REPEAT_TICKS = 20_000;

  // Clock cycles per sample tick.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return (tick_hz == 0) ? 1 : clk_hz / tick_hz;
  endfunction

  // Width of a counter holding 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: synchroniser, stable-window filter, edge, hold and
// long-press detection. Auto-repeat of the press pulse is built only with BTN_REPEAT_EN.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("btn_debounce_ch: DEPTH must be at least 2");
  end
  if (LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_ticks
    $error("btn_debounce_ch: LONG_TICKS and REPEAT_TICKS must be at least 1");
  end

  localparam int unsigned           HOLD_W   = cnt_width(LONG_TICKS);
  localparam logic [HOLD_W-1:0]     HOLD_MAX = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0]     HOLD_PRE = HOLD_W'(LONG_TICKS - 1);

  logic [1:0]        sync_q;
  // Oldest window bit is always shifted out, so only DEPTH-1 past samples are stored.
  logic [DEPTH-2:0]  hist_q, hist_d;
  logic [DEPTH-1:0]  win_next;
  logic              level_q, level_d;
  logic              level_dly_q;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              long_q, long_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rep_pulse;

  assign win_next = {sync_q[1], hist_q};

  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    hold_d  = hold_q;
    if (tick) begin
      hist_d = win_next[DEPTH-1:1];
      if (&win_next) begin
        level_d = 1'b1;
      end else if (~|win_next) begin
        level_d = 1'b0;
      end
    end
    if (!level_q) begin
      hold_d = '0;
    end else if (tick && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end
    long_d = tick && level_q && (hold_q == HOLD_PRE);
    rise_d = (level_q && !level_dly_q) || rep_pulse;
    fall_d = !level_q && level_dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      hist_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      long_q      <= 1'b0;
      hold_q      <= '0;
    end else begin
      sync_q      <= {sync_q[0], btn};
      hist_q      <= hist_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      long_q      <= long_d;
      hold_q      <= hold_d;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned       REP_W    = cnt_width(REPEAT_TICKS - 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_TICKS - 1);

  logic [REP_W-1:0] rep_q, rep_d;

  // Repeat phase only advances once the hold counter has saturated.
  always_comb begin
    rep_d     = rep_q;
    rep_pulse = 1'b0;
    if (!level_q) begin
      rep_d = '0;
    end else if (tick && (hold_q == HOLD_MAX)) begin
      if (rep_q == REP_LAST) begin
        rep_d     = '0;
        rep_pulse = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign long_press = long_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner: shared sample-tick divider plus one debounce channel per
// button. Defining BTN_REPEAT_EN adds auto-repeat press pulses after a long press.
module btn_debounce_multi
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N_CH         = DEF_N_CH,
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ      = DEF_TICK_HZ,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_long,
  output logic            o_tick
);

  if (TICK_HZ == 0 || CLK_HZ < TICK_HZ) begin : g_bad_div
    $error("btn_debounce_multi: CLK_HZ / TICK_HZ must be at least 1");
  end

  localparam int unsigned       DIV      = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned       DIV_W    = cnt_width(DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_d, tick_q;

  always_comb begin
    tick_d = (div_q == DIV_LAST);
    div_d  = tick_d ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

  // Channels sample on the registered tick so o_tick marks exactly the update cycles.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEPTH        (DEPTH),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick_q),
      .btn        (i_btn[i]),
      .level      (o_level[i]),
      .rise       (o_rise[i]),
      .fall       (o_fall[i]),
      .long_press (o_long[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi: a run-length reference model predicts every
// output each cycle; a separate monitor pops and compares after each clock edge.
module tb_btn_debounce_multi;

  localparam int unsigned N_CH         = 2;
  localparam int unsigned CLK_HZ       = 400;
  localparam int unsigned TICK_HZ      = 100;
  localparam int unsigned DIV          = CLK_HZ / TICK_HZ;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned LONG_TICKS   = 8;
  localparam int unsigned REPEAT_TICKS = 3;
  localparam int          W            = 4 * N_CH + 1;
`ifdef BTN_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] i_btn;
  logic [N_CH-1:0] o_level, o_rise, o_fall, o_long;
  logic            o_tick;

  always #5 clk = ~clk;

  btn_debounce_multi #(
    .N_CH         (N_CH),
    .CLK_HZ       (CLK_HZ),
    .TICK_HZ      (TICK_HZ),
    .DEPTH        (DEPTH),
    .LONG_TICKS   (LONG_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (i_btn),
    .o_level (o_level),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_long  (o_long),
    .o_tick  (o_tick)
  );

  logic [W-1:0]    exp_q[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  logic [N_CH-1:0] btn_drv;
  logic            rst_drv;

  // Reference model state: clocks since reset, last two input samples, run lengths of
  // identical tick samples, and the number of ticks spent with the level high.
  int unsigned k;
  bit          m_tick;
  bit          m_s1[N_CH], m_s2[N_CH];
  int          ones_run[N_CH], zeros_run[N_CH];
  bit          m_lvl[N_CH], m_prev[N_CH];
  bit          m_rise[N_CH], m_fall[N_CH], m_long[N_CH];
  int          held[N_CH];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got lvl/rise/fall/long/tick=%b, expected %b",
                  name, $time, got, exp);
  endtask

  task automatic model_reset();
    k      = 0;
    m_tick = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) begin
      m_s1[ch] = 0; m_s2[ch] = 0;
      ones_run[ch] = 0; zeros_run[ch] = DEPTH;
      m_lvl[ch] = 0; m_prev[ch] = 0;
      m_rise[ch] = 0; m_fall[ch] = 0; m_long[ch] = 0;
      held[ch] = 0;
    end
  endtask

  task automatic model_edge();
    bit t;
    t = m_tick;
    for (int ch = 0; ch < N_CH; ch++) begin
      bit lvl_old, new_lvl, rep;
      int h_next;
      lvl_old = m_lvl[ch];
      new_lvl = lvl_old;
      if (t) begin
        if (m_s2[ch]) begin ones_run[ch]++; zeros_run[ch] = 0; end
        else begin zeros_run[ch]++; ones_run[ch] = 0; end
        if (ones_run[ch] >= DEPTH) new_lvl = 1;
        else if (zeros_run[ch] >= DEPTH) new_lvl = 0;
      end
      h_next = held[ch] + ((t && lvl_old) ? 1 : 0);
      rep = REPEAT_ON && t && lvl_old && (h_next > LONG_TICKS) &&
            (((h_next - LONG_TICKS) % REPEAT_TICKS) == 0);
      m_long[ch] = t && lvl_old && (h_next == LONG_TICKS);
      m_rise[ch] = (lvl_old && !m_prev[ch]) || rep;
      m_fall[ch] = !lvl_old && m_prev[ch];
      m_prev[ch] = lvl_old;
      m_lvl[ch]  = new_lvl;
      held[ch]   = lvl_old ? h_next : 0;
      m_s2[ch]   = m_s1[ch];
      m_s1[ch]   = i_btn[ch];
    end
    m_tick = ((k % DIV) == DIV - 1);
    k++;
  endtask

  function automatic logic [W-1:0] model_out();
    logic [N_CH-1:0] l, r, f, g;
    for (int ch = 0; ch < N_CH; ch++) begin
      l[ch] = m_lvl[ch]; r[ch] = m_rise[ch]; f[ch] = m_fall[ch]; g[ch] = m_long[ch];
    end
    return {l, r, f, g, m_tick};
  endfunction

  // One clock: drive at the falling edge, predict the state after the next rising edge.
  task automatic step();
    @(negedge clk);
    i_btn = btn_drv;
    if (rst_drv && !rst) begin
      rst = 1'b1;
      #1;
      check("async_reset", {o_level, o_rise, o_fall, o_long, o_tick}, '0);
    end
    rst = rst_drv;
    if (rst) model_reset();
    else model_edge();
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input logic [N_CH-1:0] v, input int n);
    btn_drv = v;
    repeat (n) step();
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {o_level, o_rise, o_fall, o_long, o_tick}, e);
      end
    end
  end

  initial begin : driver
    rst     = 1'b1;
    rst_drv = 1'b1;
    btn_drv = '0;
    i_btn   = '0;
    model_reset();
    hold('0, 3);
    check("reset_state", {o_level, o_rise, o_fall, o_long, o_tick}, '0);
    rst_drv = 1'b0;
    hold('0, 10);

    // Clean press and release on ch0.
    hold(2'b01, 40);
    hold(2'b00, 40);

    // Bounce every 5 clocks, then settle high, then release.
    for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 2'b01 : 2'b00, 5);
    hold(2'b01, 40);
    hold(2'b00, 40);

    // Long press on ch1, then a press too short to reach the long threshold.
    hold(2'b10, 80);
    hold(2'b00, 40);
    hold(2'b10, 28);
    hold(2'b00, 40);

    // Simultaneous press, release ch0 only, then ch1.
    hold(2'b11, 40);
    hold(2'b10, 40);
    hold(2'b00, 40);

    // Reset while ch0 is held high; the channel must re-qualify afterwards.
    hold(2'b01, 40);
    rst_drv = 1'b1;
    hold(2'b01, 3);
    rst_drv = 1'b0;
    hold(2'b01, 40);
    hold(2'b00, 40);

    // Very long hold exercises saturation and auto-repeat when built in.
    hold(2'b01, 100);
    hold(2'b00, 40);

    // Random segments mixing glitches, bounces and long holds per channel.
    for (int i = 0; i < 150; i++) begin
      logic [N_CH-1:0] v;
      int              len;
      v   = btn_drv ^ N_CH'($urandom_range(1, (1 << N_CH) - 1));
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 70);
      hold(v, len);
    end
    hold('0, 40);

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
